icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Next-generation instruction-fetch stage with a parametrised set-associative, multi-word-line I-cache.
- Sits between the PC register and the IF/ID latch; misses are serviced word by word through the shared memory controller.
- Adds over the previous fetch stage:
  - registered output
  - configurable ways, sets and line size
  - valid bits and a victim policy
  - safe cancellation of an in-flight fill on branch or fence.i
  - hit/miss performance counters

Parameters:
ADDR_W, 32, address width
WAYS, 2, associativity (1 = direct mapped), power of 2
SETS, 16, sets per way, power of 2
LINE_WORDS, 4, 32-bit words per line, power of 2, >=1

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous reset, active-high
pc_in  in  ADDR_W  fetch address; bits [1:0] ignored
pc_valid_in  in  1  fetch request this cycle
branch_flag_in  in  1  redirect; squash the current fetch
fence_i_in  in  1  invalidate the whole cache
mem_req_out  in→out  1  one-cycle instruction read request (direction: out)
mem_addr_out  out  ADDR_W  word address of the request
mem_inst_in  in  32  returned word
mem_busy_in  in  2  [0] instruction port busy, [1] data port busy
mem_done_in  in  1  mem_inst_in valid this cycle
stall_req_out  out  1  combinational stall request to the pipeline controller
if_valid_out  out  1  if_pc_out/if_inst_out valid
if_pc_out  out  ADDR_W  PC of the delivered instruction
if_inst_out  out  32  delivered instruction
hit_cnt_out  out  32  hits delivered
miss_cnt_out  out  32  fills started

Behaviour:
- Reset (async, any state, including mid-fill):
  - all valid bits, victim pointers and counters cleared
  - FSM to IDLE
  - every output 0
  - a memory reply arriving after reset is ignored
- Address split: OFF=log2(LINE_WORDS), IDX=log2(SETS).
  - word offset = pc[OFF+1:2]
  - index = pc[IDX+OFF+1:OFF+2]
  - tag = remaining upper bits
- Hit (IDLE, pc_valid_in, some valid way matches tag, no branch/fence):
  - next edge: if_valid_out=1, if_pc_out=pc_in, if_inst_out=the word
  - hit_cnt_out increments
  - stall_req_out=0
  - latency 1
- Otherwise if_valid_out=0 on the next edge, so it is a single-cycle pulse per delivery.
- Miss in IDLE:
  - stall_req_out=1 combinationally
  - miss_cnt_out increments
  - latch the line base (offset zeroed), the index, the requested PC and the victim way
  - go to REQ with word counter 0
- FSM states:
  - REQ:
    - wait until mem_busy_in[0]==0 (data-port busy alone does not block)
    - assert mem_req_out for exactly one cycle, with mem_addr_out = line base + 4*counter
    - go to WAIT
  - WAIT:
    - on mem_done_in, store the word into the line buffer
    - if counter==LINE_WORDS-1, go to FILL; else counter+1 and go to REQ
  - FILL:
    - write tag, valid and line into the victim way
    - deliver the requested word (if_valid_out=1 next edge, if_pc_out = latched PC)
    - go to IDLE
  - CANCEL:
    - wait for the outstanding mem_done_in
    - discard the data
    - go to IDLE with no install and no delivery
- stall_req_out=1 in REQ, WAIT and FILL, and in IDLE on a miss. It is 0 in CANCEL and on a branch, because the pipeline is flushing.
- Victim selection:
  - the lowest-index invalid way first
  - else a per-set round-robin pointer, which advances on every install into that set
  - WAYS=1: always way 0
- branch_flag_in:
  - In IDLE: no lookup, no counter change; if_valid_out=0 next edge.
  - In REQ before the request is issued: go to IDLE.
  - In WAIT: go to CANCEL.
  - In FILL: install the line but do not deliver.
  - While branch_flag_in=1, mem_req_out=0.
- fence_i_in:
  - clears all valid bits at the edge
  - if it coincides with FILL, the line is not installed
  - during REQ/WAIT it is handled as branch_flag_in (abort/CANCEL)
  - the fence takes priority over a same-cycle hit; that lookup is treated as a branch
- Counters wrap from 2^32-1 to 0.
- A second pc_valid_in while not IDLE is ignored; the requester holds pc_in while stall_req_out=1.

Decomposition:
- Package icache_pkg: FSM state enum (IDLE, REQ, WAIT, FILL, CANCEL), functions deriving OFF/IDX/TAG widths, and the busy-bit index constants.
- Sub-module icache_way_array: one instance per way. Holds tag/valid/data storage and returns hit and word; it is written only in FILL and cleared on reset or fence.i.

Test Plan:
- Cold miss on pc 0x100: four requests to 0x100, 0x104, 0x108, 0x10C, with the word index as reply data. Required: if_inst_out=0 delivered one cycle after FILL, miss_cnt=1, stall high throughout.
- Fetch pc 0x104 after that fill: hit, delivered next edge with if_inst_out=1, no mem_req_out, hit_cnt=1.
- Fill 0x000, 0x100 and 0x200 (all index 0, tag differs):
  - third fill evicts way 0 (0x000)
  - refetch 0x100 hits
  - refetch 0x000 misses
- branch_flag_in pulse in WAIT of the second word: remaining done is absorbed, no further request, no install. Refetch of the same line misses again.
- mem_busy_in=2'b01 for 5 cycles in REQ: no request until it clears. mem_busy_in=2'b10: request issues immediately.
- rst_in asserted mid-WAIT, and fence_i_in after a fill:
  - after reset, all outputs and counters are 0
  - after the fence, the previously hit line misses

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-geometry helpers for the instruction-fetch cache.
package icache_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, CANCEL} fetch_state_e;

  localparam int unsigned BUSY_INST = 0;
  localparam int unsigned BUSY_DATA = 1;

  function automatic int unsigned off_bits(input int unsigned line_words);
    return (line_words > 1) ? $clog2(line_words) : 0;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned sets);
    return (sets > 1) ? $clog2(sets) : 0;
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_w, input int unsigned sets,
                                           input int unsigned line_words);
    return addr_w - 2 - idx_bits(sets) - off_bits(line_words);
  endfunction

  // Zero-width fields still need a 1-bit carrier signal.
  function automatic int unsigned field_w(input int unsigned bits);
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: per-set valid bit, tag and line storage with a single write port.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 24,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned OFF_W      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  input  logic [TAG_W-1:0]            rd_tag_i,
  input  logic [OFF_W-1:0]            rd_off_i,
  output logic                        hit_o,
  output logic                        valid_o,
  output logic [31:0]                 word_o,
  input  logic                        wr_en_i,
  input  logic [IDX_W-1:0]            wr_idx_i,
  input  logic [TAG_W-1:0]            wr_tag_i,
  input  logic [LINE_WORDS-1:0][31:0] wr_line_i
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]            valid_q;
  logic [TAG_W-1:0]            tag_q  [DEPTH];
  logic [LINE_WORDS-1:0][31:0] data_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed through valid_q.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign valid_o = valid_q[rd_idx_i];
  assign hit_o   = valid_o && (tag_q[rd_idx_i] == rd_tag_i);
  assign word_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/icache_fetch.sv
// Instruction-fetch stage with a set-associative I-cache filled word by word
// through the shared memory controller; output is registered.
module icache_fetch
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid_in,
  input  logic              branch_flag_in,
  input  logic              fence_i_in,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic [31:0]       mem_inst_in,
  input  logic [1:0]        mem_busy_in,
  input  logic              mem_done_in,
  output logic              stall_req_out,
  output logic              if_valid_out,
  output logic [ADDR_W-1:0] if_pc_out,
  output logic [31:0]       if_inst_out,
  output logic [31:0]       hit_cnt_out,
  output logic [31:0]       miss_cnt_out
);

  localparam int unsigned OFF_B = off_bits(LINE_WORDS);
  localparam int unsigned IDX_B = idx_bits(SETS);
  localparam int unsigned TAG_W = tag_bits(ADDR_W, SETS, LINE_WORDS);
  localparam int unsigned OFF_W = field_w(OFF_B);
  localparam int unsigned IDX_W = field_w(IDX_B);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] IDX_MASK  = ADDR_W'(SETS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);

  fetch_state_e                state_q, state_d;
  logic [OFF_W-1:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]           pc_q, pc_d;
  logic [WAY_W-1:0]            victim_q, victim_d;
  logic [LINE_WORDS-1:0][31:0] buf_q, buf_d;
  logic [(1<<IDX_W)-1:0][WAY_W-1:0] rr_q;
  logic                        if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]           if_pc_q, if_pc_d;
  logic [31:0]                 if_inst_q, if_inst_d, hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [OFF_W-1:0] lk_off, fill_off;
  logic [IDX_W-1:0] lk_idx, fill_idx;
  logic [TAG_W-1:0] lk_tag, fill_tag;
  logic [WAYS-1:0]  way_hit, way_valid, way_wr;
  logic [31:0]      way_word [WAYS];
  logic             lk_hit, victim_found, install, mem_req, stall, flush;
  logic [31:0]      lk_word;
  logic [WAY_W-1:0] victim_sel;
  logic             unused_data_busy;

  assign unused_data_busy = mem_busy_in[BUSY_DATA];
  assign flush = branch_flag_in || fence_i_in;

  assign lk_off   = OFF_W'((pc_in >> 2) & OFF_MASK);
  assign lk_idx   = IDX_W'((pc_in >> (OFF_B + 2)) & IDX_MASK);
  assign lk_tag   = TAG_W'(pc_in >> (OFF_B + IDX_B + 2));
  assign fill_off = OFF_W'((pc_q >> 2) & OFF_MASK);
  assign fill_idx = IDX_W'((pc_q >> (OFF_B + 2)) & IDX_MASK);
  assign fill_tag = TAG_W'(pc_q >> (OFF_B + IDX_B + 2));

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_wr[w] = install && (victim_q == WAY_W'(w));
    icache_way_array #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)
    ) u_way (
      .clk_i    (clk_in),
      .rst_i    (rst_in),
      .clear_i  (fence_i_in),
      .rd_idx_i (lk_idx),
      .rd_tag_i (lk_tag),
      .rd_off_i (lk_off),
      .hit_o    (way_hit[w]),
      .valid_o  (way_valid[w]),
      .word_o   (way_word[w]),
      .wr_en_i  (way_wr[w]),
      .wr_idx_i (fill_idx),
      .wr_tag_i (fill_tag),
      .wr_line_i(buf_q)
    );
  end

  always_comb begin
    lk_hit       = 1'b0;
    lk_word      = '0;
    victim_sel   = rr_q[lk_idx];
    victim_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        lk_hit  = 1'b1;
        lk_word = way_word[w];
      end
      if (!victim_found && !way_valid[w]) begin
        victim_sel   = WAY_W'(w);
        victim_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    victim_d   = victim_q;
    buf_d      = buf_q;
    if_valid_d = 1'b0;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    install    = 1'b0;
    mem_req    = 1'b0;
    stall      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pc_valid_in && !flush) begin
          if (lk_hit) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_in;
            if_inst_d  = lk_word;
            hit_cnt_d  = hit_cnt_q + 32'd1;
          end else begin
            stall      = 1'b1;
            miss_cnt_d = miss_cnt_q + 32'd1;
            pc_d       = pc_in;
            victim_d   = victim_sel;
            cnt_d      = '0;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        stall = !flush;
        if (flush) begin
          state_d = IDLE;
        end else if (!mem_busy_in[BUSY_INST]) begin
          mem_req = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = !flush;
        // A redirect in the same cycle as the reply has nothing left to absorb.
        if (mem_done_in) begin
          buf_d[cnt_q] = mem_inst_in;
          if (flush) begin
            state_d = IDLE;
          end else if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            state_d = FILL;
          end else begin
            cnt_d   = cnt_q + OFF_W'(1);
            state_d = REQ;
          end
        end else if (flush) begin
          state_d = CANCEL;
        end
      end
      FILL: begin
        stall   = !flush;
        install = !fence_i_in;
        if (!flush) begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_inst_d  = buf_q[fill_off];
        end
        state_d = IDLE;
      end
      CANCEL: begin
        if (mem_done_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      victim_q   <= '0;
      buf_q      <= '0;
      rr_q       <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      victim_q   <= victim_d;
      buf_q      <= buf_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (install && (WAYS > 1)) rr_q[fill_idx] <= rr_q[fill_idx] + WAY_W'(1);
    end
  end

  assign mem_req_out   = mem_req;
  assign mem_addr_out  = (pc_q & ~LINE_MASK) | (ADDR_W'(cnt_q) << 2);
  assign stall_req_out = stall && !rst_in;
  assign if_valid_out  = if_valid_q;
  assign if_pc_out     = if_pc_q;
  assign if_inst_out   = if_inst_q;
  assign hit_cnt_out   = hit_cnt_q;
  assign miss_cnt_out  = miss_cnt_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: transaction-level cache model, directed scenarios and random traffic.
module tb_icache_fetch;

  localparam int unsigned LW = 4, SETS = 16, WAYS = 2;

  logic        clk_in = 1'b0, rst_in, pc_valid_in, branch_flag_in, fence_i_in, mem_done_in;
  logic [31:0] pc_in, mem_inst_in;
  logic [1:0]  mem_busy_in;
  logic        mem_req_out, stall_req_out, if_valid_out;
  logic [31:0] mem_addr_out, if_pc_out, if_inst_out, hit_cnt_out, miss_cnt_out;

  always #5 clk_in = ~clk_in;

  icache_fetch #(.ADDR_W(32), .WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pc_in(pc_in), .pc_valid_in(pc_valid_in),
    .branch_flag_in(branch_flag_in), .fence_i_in(fence_i_in),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out), .mem_inst_in(mem_inst_in),
    .mem_busy_in(mem_busy_in), .mem_done_in(mem_done_in), .stall_req_out(stall_req_out),
    .if_valid_out(if_valid_out), .if_pc_out(if_pc_out), .if_inst_out(if_inst_out),
    .hit_cnt_out(hit_cnt_out), .miss_cnt_out(miss_cnt_out)
  );

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Model: resident line base per way/set, a pending fill described by how many
  // words were requested and whether a reply is owed, and expected outputs.
  bit          ok [WAYS][SETS];
  logic [31:0] line_of [WAYS][SETS];
  int unsigned rr [SETS];
  bit          fill_on, aband, outst, hash_mode, chk_en;
  int unsigned k, fvict;
  logic [31:0] fbase, fpc, oaddr, m_hits, m_misses;
  logic        exp_valid, exp_stall, exp_req;
  logic [31:0] exp_pc, exp_inst, exp_addr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (hash_mode) return ((a >> 2) * 32'h9E3779B1) ^ 32'hC0DE0000;
    return (a >> 2) % LW;
  endfunction

  function automatic int unsigned set_of(input logic [31:0] p);
    return (p >> (2 + $clog2(LW))) % SETS;
  endfunction

  function automatic logic [31:0] base_of(input logic [31:0] p);
    return p & ~(LW * 4 - 1);
  endfunction

  function automatic int find_way(input logic [31:0] p);
    for (int w = 0; w < WAYS; w++)
      if (ok[w][set_of(p)] && line_of[w][set_of(p)] == base_of(p)) return w;
    return -1;
  endfunction

  task automatic model_clear();
    foreach (ok[w, s]) ok[w][s] = 1'b0;
    foreach (rr[s]) rr[s] = 0;
    fill_on = 0; aband = 0; outst = 0; k = 0;
    m_hits = 0; m_misses = 0;
    exp_valid = 0; exp_stall = 0; exp_req = 0; exp_pc = 0; exp_inst = 0; exp_addr = 0;
  endtask

  task automatic deliver(input logic [31:0] p);
    exp_valid = 1'b1;
    exp_pc    = p;
    exp_inst  = memfn(p & ~32'd3);
  endtask

  always @(negedge clk_in) begin
    if (chk_en) begin
      check("if_valid", if_valid_out, exp_valid);
      if (exp_valid) begin
        check("if_pc", if_pc_out, exp_pc);
        check("if_inst", if_inst_out, exp_inst);
      end
      check("hit_cnt", hit_cnt_out, m_hits);
      check("miss_cnt", miss_cnt_out, m_misses);
      check("stall_req", stall_req_out, exp_stall);
      check("mem_req", mem_req_out, exp_req);
      if (exp_req) check("mem_addr", mem_addr_out, exp_addr);
    end
  end

  // Drive one cycle of inputs, predict combinational outputs, then apply the edge.
  task automatic step(input bit pv, input logic [31:0] pc, input bit br, input bit fe,
                      input logic [1:0] busy, input bit dn);
    bit flush, idle;
    int hw, s;
    pc_valid_in = pv; pc_in = pc; branch_flag_in = br; fence_i_in = fe;
    mem_busy_in = busy; mem_done_in = dn;
    mem_inst_in = dn ? memfn(oaddr) : 32'hDEADBEEF;
    flush = br || fe;
    idle  = !fill_on && !aband;
    hw    = find_way(pc);
    exp_req = 1'b0;
    if (idle) exp_stall = pv && !flush && (hw < 0);
    else if (aband) exp_stall = 1'b0;
    else begin
      exp_stall = !flush;
      exp_req   = !outst && (k < LW) && !flush && !busy[0];
      exp_addr  = fbase + 32'(4 * k);
    end
    @(posedge clk_in); #1;
    exp_valid = 1'b0;
    if (idle) begin
      if (pv && !flush) begin
        if (hw >= 0) begin
          deliver(pc);
          m_hits++;
        end else begin
          m_misses++;
          fill_on = 1; fbase = base_of(pc); fpc = pc; k = 0; outst = 0;
          s = set_of(pc);
          fvict = rr[s];
          for (int w = WAYS - 1; w >= 0; w--) if (!ok[w][s]) fvict = w;
        end
      end
    end else if (aband) begin
      if (dn) begin aband = 0; outst = 0; end
    end else if (outst) begin
      if (dn) begin
        outst = 0;
        if (flush) fill_on = 0;
      end else if (flush) begin
        fill_on = 0; aband = 1;
      end
    end else if (k < LW) begin
      if (flush) fill_on = 0;
      else if (!busy[0]) begin oaddr = fbase + 32'(4 * k); k++; outst = 1; end
    end else begin
      if (!fe) begin
        s = set_of(fbase);
        ok[fvict][s] = 1'b1; line_of[fvict][s] = fbase;
        rr[s] = (rr[s] + 1) % WAYS;
      end
      if (!flush) deliver(fpc);
      fill_on = 0;
    end
    if (fe) foreach (ok[w, s2]) ok[w][s2] = 1'b0;
  endtask

  task automatic fill_rest(input logic [31:0] pc, input logic [1:0] busy);
    for (int i = 0; i < LW; i++) begin
      step(0, pc, 0, 0, busy, 0);
      step(0, pc, 0, 0, busy, 1);
    end
    step(0, pc, 0, 0, busy, 0);
  endtask

  task automatic fill_line(input logic [31:0] pc);
    step(1, pc, 0, 0, 2'b00, 0);
    fill_rest(pc, 2'b00);
  endtask

  task automatic do_reset();
    pc_valid_in = 0; branch_flag_in = 0; fence_i_in = 0; mem_busy_in = 0; mem_done_in = 0;
    rst_in = 1'b1;
    model_clear();
    #1;
    check("rst_if_valid", if_valid_out, 0);
    check("rst_if_pc", if_pc_out, 0);
    check("rst_if_inst", if_inst_out, 0);
    check("rst_hit_cnt", hit_cnt_out, 0);
    check("rst_miss_cnt", miss_cnt_out, 0);
    check("rst_stall", stall_req_out, 0);
    check("rst_mem_req", mem_req_out, 0);
    check("rst_mem_addr", mem_addr_out, 0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  initial begin
    logic [31:0] cur_pc;
    rst_in = 1'b1; pc_in = 0; pc_valid_in = 0; branch_flag_in = 0; fence_i_in = 0;
    mem_busy_in = 0; mem_done_in = 0; mem_inst_in = 0; oaddr = 0;
    hash_mode = 0; chk_en = 0;
    @(posedge clk_in); #1;
    do_reset();
    chk_en = 1;

    fill_line(32'h100);
    check("cold_valid", if_valid_out, 1);
    check("cold_pc", if_pc_out, 32'h100);
    check("cold_inst", if_inst_out, 0);
    check("cold_miss_cnt", miss_cnt_out, 1);
    step(1, 32'h104, 0, 0, 2'b00, 0);
    check("hit_valid", if_valid_out, 1);
    check("hit_inst", if_inst_out, 1);
    check("hit_cnt_one", hit_cnt_out, 1);
    step(0, 0, 0, 0, 2'b00, 0);

    do_reset();
    fill_line(32'h000);
    fill_line(32'h100);
    fill_line(32'h200);
    step(1, 32'h108, 0, 0, 2'b00, 0);
    check("evict_keep_hit", if_valid_out, 1);
    check("evict_keep_inst", if_inst_out, 2);
    fill_line(32'h000);
    check("evict_refetch_miss", miss_cnt_out, 4);

    step(1, 32'h300, 0, 0, 2'b00, 0);
    step(0, 32'h300, 0, 0, 2'b00, 0);
    step(0, 32'h300, 0, 0, 2'b00, 1);
    step(0, 32'h300, 0, 0, 2'b00, 0);
    step(0, 32'h300, 1, 0, 2'b00, 0);
    step(0, 32'h300, 0, 0, 2'b00, 0);
    step(0, 32'h300, 0, 0, 2'b00, 1);
    repeat (3) step(0, 32'h300, 0, 0, 2'b00, 0);
    fill_line(32'h300);
    check("cancel_refetch_miss", miss_cnt_out, 6);

    step(1, 32'h404, 0, 0, 2'b00, 0);
    repeat (5) step(0, 32'h404, 0, 0, 2'b01, 0);
    step(0, 32'h404, 0, 0, 2'b00, 0);
    step(0, 32'h404, 0, 0, 2'b00, 1);
    fill_rest(32'h404, 2'b10);
    check("busy_deliver_pc", if_pc_out, 32'h404);

    step(1, 32'h500, 0, 0, 2'b00, 0);
    step(0, 32'h500, 0, 0, 2'b00, 0);
    step(0, 32'h500, 0, 0, 2'b00, 0);
    do_reset();
    step(0, 0, 0, 0, 2'b00, 1);
    repeat (3) step(0, 0, 0, 0, 2'b00, 0);
    check("late_reply_ignored", miss_cnt_out, 0);

    fill_line(32'h600);
    step(1, 32'h600, 0, 0, 2'b00, 0);
    check("pre_fence_hit", if_valid_out, 1);
    step(0, 0, 0, 1, 2'b00, 0);
    step(1, 32'h600, 0, 0, 2'b00, 0);
    check("post_fence_miss", miss_cnt_out, 2);
    fill_rest(32'h600, 2'b00);

    do_reset();
    hash_mode = 1;
    cur_pc = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!fill_on && !aband)
        cur_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) |
                 ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 99) < 60, cur_pc, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 2, {1'($urandom_range(0, 1)), $urandom_range(0, 99) < 30},
           outst && ($urandom_range(0, 99) < 40));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
